// File: rtl/clkgen_pkg.sv
// ---------------------------------------------------------------------------
// clkgen_pkg
// Shared types and defaults for the clk_sys strobe generator.
//   turbo_t     : CPU turbo selection (x1 / x2 / x4, with code 3 also x4)
//   sub_period  : clk_sys cycles per CPU sub-period for a given turbo level
//   DEF_*       : default divider settings for the standard clk_sys rate
// ---------------------------------------------------------------------------
package clkgen_pkg;

    typedef enum logic [1:0] {
        TURBO_X1  = 2'd0,
        TURBO_X2  = 2'd1,
        TURBO_X4  = 2'd2,
        TURBO_X4B = 2'd3
    } turbo_t;

    localparam int DEF_CPU_DIV      = 28;
    localparam int DEF_F2_OFFSET    = 2;
    localparam int DEF_PERIPH_PHASE = 4;
    localparam int DEF_PIX_DIV      = 6;
    localparam int DEF_PS2_DIV      = 3571;

    // Code 3 is an alias of x4 so that every turbo code yields a valid rate.
    function automatic int sub_period(input int cpu_div, input turbo_t t);
        int result;
        case (t)
            TURBO_X1: result = cpu_div;
            TURBO_X2: result = cpu_div >> 1;
            default:  result = cpu_div >> 2;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/strobe_div.sv
// ---------------------------------------------------------------------------
// strobe_div
// Free-running modulo-DIV counter with a registered one-cycle strobe.
// The strobe fires in the cycle after the counter reads 0 and, when PHASE_B
// is non-zero, also in the cycle after it reads PHASE_B.
//   clk_sys  in  system clock
//   reset_n  in  asynchronous active-low reset
//   strobe   out registered strobe
// ---------------------------------------------------------------------------
module strobe_div
    import clkgen_pkg::*;
#(
    parameter int DIV     = DEF_PIX_DIV,
    parameter int PHASE_B = 0
) (
    input  logic clk_sys,
    input  logic reset_n,
    output logic strobe
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_reg;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_reg <= '0;
            strobe  <= 1'b0;
        end else begin
            strobe  <= (cnt_reg == '0) || (cnt_reg == W'(PHASE_B));
            cnt_reg <= (cnt_reg == W'(DIV - 1)) ? '0 : cnt_reg + W'(1);
        end
    end

endmodule

// File: rtl/clk_strobe_gen.sv
// ---------------------------------------------------------------------------
// clk_strobe_gen
// Turns clk_sys into one-cycle clock-enable strobes for the CPU, DMA/PIT,
// CRT, scandoubler and keyboard. Every output is registered and each strobe
// is high for exactly one clk_sys cycle.
//
// Ports:
//   clk_sys    in   system clock
//   reset_n    in   asynchronous active-low reset
//   turbo      in   [1:0] 0=x1, 1=x2, 2/3=x4
//   cpu_hold   in   masks clk_f1/clk_f2; counters keep running
//   clk_f1     out  CPU phase-1 strobe
//   clk_f2     out  CPU phase-2 strobe (F2_OFFSET cycles after clk_f1)
//   clk_per    out  PIT/DMA strobe, once per base CPU period
//   clk_pix    out  pixel strobe
//   clk_pix2x  out  double-rate pixel strobe
//   clk_ps2    out  PS/2 sample strobe
//   turbo_act  out  [1:0] turbo level currently in effect
//
// Build option: define CLKGEN_PS2_STROBE_EN to build the PS/2 divider;
// without it clk_ps2 is tied low and PS2_DIV is not used.
// ---------------------------------------------------------------------------
module clk_strobe_gen
    import clkgen_pkg::*;
#(
    parameter int CPU_DIV      = DEF_CPU_DIV,
    parameter int F2_OFFSET    = DEF_F2_OFFSET,
    parameter int PERIPH_PHASE = DEF_PERIPH_PHASE,
    parameter int PIX_DIV      = DEF_PIX_DIV,
    parameter int PS2_DIV      = DEF_PS2_DIV
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [1:0] turbo,
    input  logic       cpu_hold,
    output logic       clk_f1,
    output logic       clk_f2,
    output logic       clk_per,
    output logic       clk_pix,
    output logic       clk_pix2x,
    output logic       clk_ps2,
    output logic [1:0] turbo_act
);

    localparam int CW = $clog2(CPU_DIV);

    // Elaboration-time sanity checks on the divider settings.
    if ((CPU_DIV % 4) != 0) begin : g_bad_cpu_div
        $error("clk_strobe_gen: CPU_DIV must be divisible by 4");
    end
    if (F2_OFFSET >= CPU_DIV / 4) begin : g_bad_f2_offset
        $error("clk_strobe_gen: F2_OFFSET must be < CPU_DIV/4");
    end
    if (PERIPH_PHASE >= CPU_DIV) begin : g_bad_periph_phase
        $error("clk_strobe_gen: PERIPH_PHASE must be < CPU_DIV");
    end
    if ((PIX_DIV < 2) || ((PIX_DIV % 2) != 0)) begin : g_bad_pix_div
        $error("clk_strobe_gen: PIX_DIV must be even and >= 2");
    end

    // ------------------------------------------------------------------
    // CPU path: base-period counter plus turbo sub-period counter
    // ------------------------------------------------------------------
    logic [CW-1:0] cpu_cnt_reg;
    logic [CW-1:0] sub_cnt_reg;
    turbo_t        turbo_q_reg;
    logic [CW-1:0] sub_last;
    logic          cpu_wrap;

    assign sub_last = CW'(sub_period(CPU_DIV, turbo_q_reg) - 1);
    assign cpu_wrap = (cpu_cnt_reg == CW'(CPU_DIV - 1));

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cpu_cnt_reg <= '0;
            sub_cnt_reg <= '0;
            turbo_q_reg <= TURBO_X1;
            clk_f1      <= 1'b0;
            clk_f2      <= 1'b0;
            clk_per     <= 1'b0;
        end else begin
            // Hold only masks the strobes; the counters never pause, so the
            // phase grid is preserved across a hold window.
            clk_f1  <= (sub_cnt_reg == '0) && !cpu_hold;
            clk_f2  <= (sub_cnt_reg == CW'(F2_OFFSET)) && !cpu_hold;
            clk_per <= (cpu_cnt_reg == CW'(PERIPH_PHASE));

            if (cpu_wrap) begin
                // Turbo is only accepted at the base-period boundary, and the
                // sub counter restarts with it, so a rate change can never
                // produce a short or stretched sub-period.
                cpu_cnt_reg <= '0;
                sub_cnt_reg <= '0;
                turbo_q_reg <= turbo_t'(turbo);
            end else begin
                cpu_cnt_reg <= cpu_cnt_reg + CW'(1);
                sub_cnt_reg <= (sub_cnt_reg == sub_last) ? '0 : sub_cnt_reg + CW'(1);
            end
        end
    end

    assign turbo_act = turbo_q_reg;

    // ------------------------------------------------------------------
    // Pixel strobes. Two identical counters share clock and reset, so they
    // stay in lock-step; the 2x copy adds a second tap at PIX_DIV/2.
    // ------------------------------------------------------------------
    strobe_div #(
        .DIV     (PIX_DIV),
        .PHASE_B (0)
    ) u_pix_div (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .strobe  (clk_pix)
    );

    strobe_div #(
        .DIV     (PIX_DIV),
        .PHASE_B (PIX_DIV / 2)
    ) u_pix2x_div (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .strobe  (clk_pix2x)
    );

    // ------------------------------------------------------------------
    // PS/2 sampling strobe
    // ------------------------------------------------------------------
`ifdef CLKGEN_PS2_STROBE_EN
    strobe_div #(
        .DIV     (PS2_DIV),
        .PHASE_B (0)
    ) u_ps2_div (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .strobe  (clk_ps2)
    );
`else
    assign clk_ps2 = 1'b0;
`endif

endmodule

// File: tb/tb_clk_strobe_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_strobe_gen
// Self-checking bench for clk_strobe_gen with default parameters.
// The reference model counts clk_sys edges since reset release and derives
// every strobe from modulo arithmetic on that edge count; directed scenarios
// add hand-computed edge lists on top.
// ---------------------------------------------------------------------------
module tb_clk_strobe_gen;

    localparam int CPU_DIV   = 28;
    localparam int F2_OFF    = 2;
    localparam int PER_PHASE = 4;
    localparam int PIX_DIV   = 6;
    localparam int PS2_DIV   = 3571;
`ifdef CLKGEN_PS2_STROBE_EN
    localparam int PS2_ON = 1;
`else
    localparam int PS2_ON = 0;
`endif

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic [1:0] turbo;
    logic       cpu_hold;
    logic       clk_f1, clk_f2, clk_per, clk_pix, clk_pix2x, clk_ps2;
    logic [1:0] turbo_act;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    clk_strobe_gen dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .turbo     (turbo),
        .cpu_hold  (cpu_hold),
        .clk_f1    (clk_f1),
        .clk_f2    (clk_f2),
        .clk_per   (clk_per),
        .clk_pix   (clk_pix),
        .clk_pix2x (clk_pix2x),
        .clk_ps2   (clk_ps2),
        .turbo_act (turbo_act)
    );

    always #5 clk_sys = ~clk_sys;

    // ---------------- reference model ----------------
    int   n = 0;          // clk_sys rising edges since reset release
    int   m_turbo = 0;    // turbo level in effect
    logic exp_f1 = 0, exp_f2 = 0, exp_per = 0, exp_pix = 0, exp_pix2x = 0, exp_ps2 = 0;

    // CPU strobes per base period: 1, 2 or 4.
    function automatic int sub_len(input int t);
        if (t == 0) return CPU_DIV;
        if (t == 1) return CPU_DIV / 2;
        return CPU_DIV / 4;
    endfunction

    always @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            n         <= 0;
            m_turbo   <= 0;
            exp_f1    <= 1'b0;
            exp_f2    <= 1'b0;
            exp_per   <= 1'b0;
            exp_pix   <= 1'b0;
            exp_pix2x <= 1'b0;
            exp_ps2   <= 1'b0;
        end else begin
            exp_f1    <= (((n % CPU_DIV) % sub_len(m_turbo)) == 0) && !cpu_hold;
            exp_f2    <= (((n % CPU_DIV) % sub_len(m_turbo)) == F2_OFF) && !cpu_hold;
            exp_per   <= ((n % CPU_DIV) == PER_PHASE);
            exp_pix   <= ((n % PIX_DIV) == 0);
            exp_pix2x <= ((n % (PIX_DIV / 2)) == 0);
            exp_ps2   <= (PS2_ON != 0) && ((n % PS2_DIV) == 0);
            if ((n % CPU_DIV) == CPU_DIV - 1) m_turbo <= int'(turbo);
            n <= n + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0d want %0d", name, n, act, exp_v);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_sys) begin
        if (chk_en) begin
            chk("f1",        32'(clk_f1),    32'(exp_f1));
            chk("f2",        32'(clk_f2),    32'(exp_f2));
            chk("per",       32'(clk_per),   32'(exp_per));
            chk("pix",       32'(clk_pix),   32'(exp_pix));
            chk("pix2x",     32'(clk_pix2x), 32'(exp_pix2x));
            chk("ps2",       32'(clk_ps2),   32'(exp_ps2));
            chk("turbo_act", 32'(turbo_act), 32'(m_turbo));
        end
    end

    // ---------------- directed helpers ----------------
    int q_f1[$], q_f2[$], q_per[$];
    int want[$];

    task automatic wait_edge(input int k);
        int guard = 0;
        while (n < k && guard < 5000) begin
            @(negedge clk_sys);
            guard++;
        end
        if (n < k) chk("wait_edge_timeout", 32'(n), 32'(k));
    endtask

    task automatic check_list(input string name, input int got[$], input int exp_q[$]);
        chk({name, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            chk(name, 32'(got[i]), 32'(exp_q[i]));
    endtask

    task automatic record(input int e);
        if (clk_f1)  q_f1.push_back(e);
        if (clk_f2)  q_f2.push_back(e);
        if (clk_per) q_per.push_back(e);
    endtask

    task automatic clear_lists();
        q_f1.delete();
        q_f2.delete();
        q_per.delete();
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_f1"},    32'(clk_f1),    0);
        chk({tag, "_f2"},    32'(clk_f2),    0);
        chk({tag, "_per"},   32'(clk_per),   0);
        chk({tag, "_pix"},   32'(clk_pix),   0);
        chk({tag, "_pix2x"}, 32'(clk_pix2x), 0);
        chk({tag, "_ps2"},   32'(clk_ps2),   0);
        chk({tag, "_turbo"}, 32'(turbo_act), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt_fx;
        int cnt_pix;

        turbo    = 2'd0;
        cpu_hold = 1'b0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk_en = 1'b1;
        chk_all_zero("reset");

        // Scenario 1: default x1 pattern after release.
        reset_n = 1'b1;
        clear_lists();
        for (int e = 1; e <= 60; e++) begin
            wait_edge(e);
            record(e);
            if (e == 1) begin
                chk("e1_f1", 32'(clk_f1), 1);
                chk("e1_pix", 32'(clk_pix), 1);
                chk("e1_pix2x", 32'(clk_pix2x), 1);
                chk("e1_ps2", 32'(clk_ps2), 32'(PS2_ON));
            end
            if (e == 4) begin
                chk("e4_pix", 32'(clk_pix), 0);
                chk("e4_pix2x", 32'(clk_pix2x), 1);
            end
            if (e == 7) chk("e7_pix", 32'(clk_pix), 1);
        end
        want = '{1, 29, 57};     check_list("s1_f1", q_f1, want);
        want = '{3, 31, 59};     check_list("s1_f2", q_f2, want);
        want = '{5, 33};         check_list("s1_per", q_per, want);
        wait_edge(PS2_DIV + 1);
        chk("ps2_period", 32'(clk_ps2), 32'(PS2_ON));
        $display("scenario 1: x1 pattern and divider strobes checked up to edge %0d", n);

        // Scenarios 2/3: x4 requested at edge 10, back to x1 at edge 40.
        do_reset();
        clear_lists();
        for (int e = 1; e <= 90; e++) begin
            wait_edge(e);
            record(e);
            if (e == 27) chk("s2_turbo_before", 32'(turbo_act), 0);
            if (e == 28) chk("s2_turbo_after", 32'(turbo_act), 2);
            if (e == 10) turbo = 2'd2;
            if (e == 40) turbo = 2'd0;
        end
        want = '{1, 29, 36, 43, 50, 57, 85};  check_list("s2_f1", q_f1, want);
        want = '{3, 31, 38, 45, 52, 59, 87};  check_list("s2_f2", q_f2, want);
        want = '{5, 33, 61, 89};              check_list("s2_per", q_per, want);
        chk("s3_turbo_final", 32'(turbo_act), 0);
        $display("scenario 2/3: turbo x1->x4->x1 checked up to edge %0d", n);

        // Scenario 4: cpu_hold seen on edges 20..80.
        do_reset();
        clear_lists();
        cnt_fx  = 0;
        cnt_pix = 0;
        for (int e = 1; e <= 90; e++) begin
            wait_edge(e);
            record(e);
            if (e >= 20 && e <= 80) begin
                cnt_fx  += int'(clk_f1) + int'(clk_f2);
                cnt_pix += int'(clk_pix);
            end
            if (e == 19) cpu_hold = 1'b1;
            if (e == 80) cpu_hold = 1'b0;
        end
        chk("s4_fx_in_hold", 32'(cnt_fx), 0);
        chk("s4_pix_in_hold", 32'(cnt_pix), 10);
        want = '{1, 85};          check_list("s4_f1", q_f1, want);
        want = '{5, 33, 61, 89};  check_list("s4_per", q_per, want);
        $display("scenario 4: cpu_hold window checked up to edge %0d", n);

        // Scenario 6: async reset between edges while running at x4.
        turbo = 2'd2;
        wait_edge(130);
        chk("s6_turbo_pre", 32'(turbo_act), 2);
        @(posedge clk_sys);
        #3;
        reset_n = 1'b0;
        turbo   = 2'd0;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk_sys);
        @(negedge clk_sys);
        reset_n = 1'b1;
        clear_lists();
        for (int e = 1; e <= 60; e++) begin
            wait_edge(e);
            record(e);
            if (e == 1) chk("s6_turbo_post", 32'(turbo_act), 0);
        end
        want = '{1, 29, 57};  check_list("s6_f1", q_f1, want);
        want = '{3, 31, 59};  check_list("s6_f2", q_f2, want);
        want = '{5, 33};      check_list("s6_per", q_per, want);
        $display("scenario 6: async reset and restart checked up to edge %0d", n);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
